// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg : shared encodings, types and line-addressing helper for the board
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

    localparam int CELL_W  = 4;
    localparam int N_CELLS = 16;
    localparam int BOARD_W = CELL_W * N_CELLS;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    localparam int unsigned DEF_WIN_EXP   = 11;
    localparam int unsigned DEF_SPAWN_EXP = 1;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SLIDE  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SPAWN  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // Element [15] is cell1 (bits 63:60), so 0-based cell c lives at element ~c.
    typedef logic [N_CELLS-1:0][CELL_W-1:0] board_t;
    typedef logic [3:0][CELL_W-1:0]         line_t;

    // 0-based cell index of position pos (0 = wall side) in line number ln for dir.
    function automatic logic [3:0] line_cell(input logic [1:0] dir,
                                             input logic [1:0] ln,
                                             input logic [1:0] pos);
        logic [1:0] rev;
        rev = 2'd3 - pos;
        case (dir)
            DIR_LEFT:  return {ln, pos};
            DIR_RIGHT: return {ln, rev};
            DIR_UP:    return {pos, ln};
            default:   return {rev, ln};
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/move_sequencer_if.sv
// ---------------------------------------------------------------------------
// move_sequencer_if : move request / board bus between game FSM and sequencer
// Rev 1.0  (score signal present only when SCORE_EN is defined)
// ---------------------------------------------------------------------------
`default_nettype none

interface move_sequencer_if;
  import game_pkg::*;

  logic               move_req;
  logic [1:0]         move_dir;
  logic [BOARD_W-1:0] board_in;
  logic [BOARD_W-1:0] board_out;
  logic               busy;
  logic               done;
  logic               moved;
  logic               update;
  logic               win;
`ifdef SCORE_EN
  logic [23:0]        score;
`endif

  modport master (
    output move_req, move_dir, board_in,
    input  board_out, busy, done, moved, update, win
`ifdef SCORE_EN
    , input score
`endif
  );

  modport slave (
    input  move_req, move_dir, board_in,
    output board_out, busy, done, moved, update, win
`ifdef SCORE_EN
    , output score
`endif
  );

endinterface

`default_nettype wire

// File: rtl/line_merge.sv
// ---------------------------------------------------------------------------
// line_merge : combinational compact-and-merge of one 4-cell line toward [0]
// Rev 1.0  (merge score output present only when SCORE_EN is defined)
// ---------------------------------------------------------------------------
`default_nettype none

module line_merge
  import game_pkg::*;
(
  input  wire line_t       line_in,
  output line_t            line_out
`ifdef SCORE_EN
  , output logic [16:0]    score
`endif
);

  // Fifth slot stays zero so the pair look-ahead never matches past the end.
  logic [CELL_W-1:0] cmp [5];
  logic [2:0]        n_in;
  logic [2:0]        n_out;
  logic              skip;
  logic [CELL_W-1:0] merged;

  always_comb begin
    for (int k = 0; k < 5; k++) cmp[k] = '0;
    n_in = '0;
    for (int k = 0; k < 4; k++) begin
      if (line_in[k] != '0) begin
        cmp[n_in] = line_in[k];
        n_in      = n_in + 3'd1;
      end
    end
  end

  always_comb begin
    line_out = '0;
    n_out    = '0;
    skip     = 1'b0;
    merged   = '0;
`ifdef SCORE_EN
    score    = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[i] != '0) begin
        if (cmp[i+1] == cmp[i]) begin
          merged = (cmp[i] == 4'hF) ? 4'hF : cmp[i] + 4'd1;
          line_out[n_out[1:0]] = merged;
`ifdef SCORE_EN
          score = score + (17'd1 << merged);
`endif
          skip = 1'b1;
        end else begin
          line_out[n_out[1:0]] = cmp[i];
        end
        n_out = n_out + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_sequencer.sv
// ---------------------------------------------------------------------------
// move_sequencer : capture board, slide 4 lines, spawn tile, commit one move
// Rev 1.0  (SCORE_EN adds a saturating 24-bit score output)
// ---------------------------------------------------------------------------
`default_nettype none

module move_sequencer
  import game_pkg::*;
#(
  parameter int unsigned WIN_EXP   = DEF_WIN_EXP,
  parameter int unsigned SPAWN_EXP = DEF_SPAWN_EXP,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  wire logic         clock,
  input  wire logic         reset,
  move_sequencer_if.slave   bus
);

  localparam logic [CELL_W-1:0] WIN_CELL   = CELL_W'(WIN_EXP);
  localparam logic [CELL_W-1:0] SPAWN_CELL = CELL_W'(SPAWN_EXP);

  state_t      state;
  state_t      next_state;
  board_t      work;
  board_t      snap;
  board_t      slid;
  logic [1:0]  dir;
  logic [1:0]  line_cnt;
  logic [15:0] lfsr;
  logic [3:0]  scan_idx;
  logic [3:0]  scan_cnt;
  logic        moved_q;
  logic        cell_empty;
  logic        win;
  line_t       line_raw;
  line_t       line_new;

`ifdef SCORE_EN
  logic [16:0] line_score;
  logic [23:0] score;
  logic [24:0] score_sum;
  assign score_sum = {1'b0, score} + 25'(line_score);
`endif

  always_comb begin
    line_raw = '0;
    for (int k = 0; k < 4; k++) line_raw[k] = work[~line_cell(dir, line_cnt, 2'(k))];
  end

  line_merge u_line_merge (
    .line_in  (line_raw),
    .line_out (line_new)
`ifdef SCORE_EN
    , .score  (line_score)
`endif
  );

  always_comb begin
    slid = work;
    for (int k = 0; k < 4; k++) slid[~line_cell(dir, line_cnt, 2'(k))] = line_new[k];
  end

  assign cell_empty = (work[~scan_idx] == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (bus.move_req) next_state = ST_SLIDE;
      ST_SLIDE:  if (line_cnt == 2'd3) next_state = ST_CHECK;
      ST_CHECK:  next_state = (work != snap) ? ST_SPAWN : ST_COMMIT;
      ST_SPAWN:  if (cell_empty || scan_cnt == 4'd15) next_state = ST_COMMIT;
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1; free-running.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      work     <= '0;
      snap     <= '0;
      dir      <= DIR_LEFT;
      line_cnt <= '0;
      scan_idx <= '0;
      scan_cnt <= '0;
      moved_q  <= 1'b0;
`ifdef SCORE_EN
      score    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.move_req) begin
            work     <= bus.board_in;
            snap     <= bus.board_in;
            dir      <= bus.move_dir;
            line_cnt <= '0;
          end
        end
        ST_SLIDE: begin
          work     <= slid;
          line_cnt <= line_cnt + 2'd1;
`ifdef SCORE_EN
          score    <= score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
`endif
        end
        ST_CHECK: begin
          moved_q  <= (work != snap);
          scan_idx <= lfsr[3:0];
          scan_cnt <= '0;
        end
        ST_SPAWN: begin
          if (cell_empty) begin
            work[~scan_idx] <= SPAWN_CELL;
          end else begin
            scan_idx <= scan_idx + 4'd1;
            scan_cnt <= scan_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    win = 1'b0;
    for (int c = 0; c < N_CELLS; c++) if (work[c] == WIN_CELL) win = 1'b1;
  end

  assign bus.board_out = work;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_COMMIT);
  assign bus.moved     = moved_q;
  assign bus.update    = (state == ST_COMMIT) && moved_q;
  assign bus.win       = win;
`ifdef SCORE_EN
  assign bus.score     = score;
`endif

endmodule

`default_nettype wire

// File: tb/tb_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_move_sequencer : directed + random moves checked against a board model
// Rev 1.0  (score is also checked when SCORE_EN is defined)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_move_sequencer;
  import game_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  move_sequencer_if bif ();

  move_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] ref_lfsr;
  longint model_score = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clock) ref_lfsr <= reset ? DEF_LFSR_SEED : lfsr_next(ref_lfsr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int get_cell(input logic [63:0] b, input int c);
    return int'(b[(15-c)*4 +: 4]);
  endfunction

  // Board after sliding/merging every line toward the wall of direction d.
  function automatic logic [63:0] slide_model(input logic [63:0] b, input logic [1:0] d,
                                              output longint pts);
    logic [63:0] r;
    int q[$];
    int res[$];
    int pos[4];
    int row, col, i, v;
    r   = b;
    pts = 0;
    for (int L = 0; L < 4; L++) begin
      q.delete();
      res.delete();
      for (int k = 0; k < 4; k++) begin
        case (d)
          2'b00:   begin row = L;     col = k;     end
          2'b01:   begin row = L;     col = 3 - k; end
          2'b11:   begin row = k;     col = L;     end
          default: begin row = 3 - k; col = L;     end
        endcase
        pos[k] = row * 4 + col;
        if (get_cell(b, pos[k]) != 0) q.push_back(get_cell(b, pos[k]));
      end
      i = 0;
      while (i < q.size()) begin
        if (i + 1 < q.size() && q[i] == q[i+1]) begin
          v = (q[i] + 1 > 15) ? 15 : q[i] + 1;
          res.push_back(v);
          pts += (64'd1 << v);
          i += 2;
        end else begin
          res.push_back(q[i]);
          i += 1;
        end
      end
      while (res.size() < 4) res.push_back(0);
      for (int k = 0; k < 4; k++) r[(15-pos[k])*4 +: 4] = 4'(res[k]);
    end
    return r;
  endfunction

  function automatic logic has_win(input logic [63:0] b);
    for (int c = 0; c < 16; c++) if (get_cell(b, c) == int'(DEF_WIN_EXP)) return 1'b1;
    return 1'b0;
  endfunction

  // One full move; req is held high through the move to show it is ignored.
  task automatic run_move(input string tag, input logic [63:0] b, input logic [1:0] d,
                          input bit force15, output logic [63:0] result);
    logic [63:0] exp_b;
    logic [15:0] lv, pv;
    longint pts;
    logic chg;
    int start, spawn_cycles, lat, n;
    bit seen;
    exp_b = slide_model(b, d, pts);
    chg   = (exp_b != b);
    @(negedge clock);
    if (force15) begin
      for (int w = 0; w < 200; w++) begin
        pv = ref_lfsr;
        for (int s = 0; s < 5; s++) pv = lfsr_next(pv);
        if (pv[3:0] == 4'hF) break;
        @(negedge clock);
      end
    end
    bif.move_req = 1'b1;
    bif.move_dir = d;
    bif.board_in = b;
    @(posedge clock); #1;
    bif.board_in = {$urandom, $urandom};
    bif.move_dir = 2'($urandom_range(0, 3));
    chk({tag, "_busy"}, bif.busy, 1'b1);
    repeat (4) @(posedge clock);
    #1;
    lv = ref_lfsr;
    spawn_cycles = 0;
    if (chg) begin
      start = int'(lv[3:0]);
      for (int j = 0; j < 16; j++) begin
        if (get_cell(exp_b, (start + j) % 16) == 0) begin
          exp_b[(15-((start + j) % 16))*4 +: 4] = 4'(DEF_SPAWN_EXP);
          spawn_cycles = j + 1;
          break;
        end
      end
      if (spawn_cycles == 0) spawn_cycles = 16;
    end
    lat  = 5 + spawn_cycles;
    n    = 4;
    seen = bif.done;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      seen = bif.done;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_board"}, bif.board_out, exp_b);
    chk({tag, "_moved"}, bif.moved, chg);
    chk({tag, "_update"}, bif.update, chg);
    chk({tag, "_win"}, bif.win, has_win(exp_b));
    model_score += pts;
    if (model_score > 64'hFFFFFF) model_score = 64'hFFFFFF;
`ifdef SCORE_EN
    chk({tag, "_score"}, bif.score, model_score[23:0]);
`endif
    @(posedge clock); #1;
    chk({tag, "_done_low"}, bif.done, 1'b0);
    chk({tag, "_update_low"}, bif.update, 1'b0);
    chk({tag, "_idle"}, bif.busy, 1'b0);
    chk({tag, "_hold"}, bif.board_out, exp_b);
    @(negedge clock);
    bif.move_req = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_req_commit_ignored"}, bif.busy, 1'b0);
    result = exp_b;
  endtask

  initial begin
    logic [63:0] res, rb;
    bit seen;
    bif.move_req = 1'b0;
    bif.move_dir = 2'b00;
    bif.board_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_board", bif.board_out, 64'h0);
    chk("rst_busy", bif.busy, 1'b0);
    chk("rst_done", bif.done, 1'b0);
    chk("rst_moved", bif.moved, 1'b0);
    chk("rst_update", bif.update, 1'b0);
    chk("rst_win", bif.win, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    run_move("pairs", 64'h1122_0000_0000_0000, DIR_LEFT, 1'b0, res);
    chk("pairs_row1", res[63:56], 8'h23);
    run_move("triple", 64'h2220_0000_0000_0000, DIR_LEFT, 1'b0, res);
    chk("triple_row1", res[63:56], 8'h32);
    run_move("nomove", 64'h1234_1234_1234_1234, DIR_LEFT, 1'b0, res);
    chk("nomove_board", res, 64'h1234_1234_1234_1234);
    run_move("win", 64'h0000_A000_0000_A000, DIR_UP, 1'b0, res);
    chk("win_cell1", res[63:60], 4'hB);
    chk("win_hold", bif.win, 1'b1);
    run_move("wrap", 64'h1123_4567_89AB_CDEF, DIR_RIGHT, 1'b1, res);
    chk("wrap_cell1", res[63:60], 4'(DEF_SPAWN_EXP));
    run_move("down", 64'h1000_1000_2000_2000, DIR_DOWN, 1'b0, res);
    run_move("satur", 64'hFF00_0000_0000_0000, DIR_LEFT, 1'b0, res);

    // Abort in the third slide cycle.
    @(negedge clock);
    bif.move_req = 1'b1;
    bif.move_dir = DIR_LEFT;
    bif.board_in = 64'h1111_2222_3333_4444;
    @(posedge clock); #1;
    bif.move_req = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy", bif.busy, 1'b0);
    chk("abort_board", bif.board_out, 64'h0);
    chk("abort_done", bif.done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    model_score = 0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (bif.done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 1'b0);
    run_move("after_abort", 64'h0101_0000_2200_0003, DIR_RIGHT, 1'b0, res);

    for (int t = 0; t < 30; t++) begin
      for (int c = 0; c < 16; c++)
        rb[(15-c)*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 4));
      run_move("rand", rb, 2'($urandom_range(0, 3)), 1'b0, res);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
